// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: op encoding, FSM states and count-width helper.
package shift_pkg;

  typedef enum logic [2:0] {
    OpSll = 3'b000,
    OpSrl = 3'b001,
    OpSla = 3'b010,
    OpSra = 3'b011,
    OpRol = 3'b100,
    OpRor = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Counter must hold the value BUS itself (full-width shift), hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned bus);
    return $clog2(bus) + 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; rotate paths exist only with SHIFT_ROTATE_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned BUS = 4
) (
  input  op_e            op_i,
  input  logic [BUS-1:0] val_i,
  output logic [BUS-1:0] nxt_o,
  output logic           msb_changed_o
);

  always_comb begin
    nxt_o = val_i;
    case (op_i)
      OpSll, OpSla: nxt_o = {val_i[BUS-2:0], 1'b0};
      OpSrl:        nxt_o = {1'b0, val_i[BUS-1:1]};
      OpSra:        nxt_o = {val_i[BUS-1], val_i[BUS-1:1]};
`ifdef SHIFT_ROTATE_EN
      OpRol:        nxt_o = {val_i[BUS-2:0], val_i[BUS-1]};
      OpRor:        nxt_o = {val_i[0], val_i[BUS-1:1]};
`endif
      default:      nxt_o = val_i;
    endcase
    msb_changed_o = nxt_o[BUS-1] ^ val_i[BUS-1];
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: one bit per clock, registered result with a one-cycle done pulse.
// Rotates (ROL/ROR) are enabled by defining SHIFT_ROTATE_EN; otherwise they act as reserved.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int unsigned BUS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [BUS-1:0] a,
  input  logic [BUS-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [BUS-1:0] y,
  output logic           ovf
);

  localparam int unsigned CntW   = cnt_width(BUS);
  localparam int unsigned LogBus = $clog2(BUS);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BUS-1:0]  work_q, work_d;
  logic            sticky_q, sticky_d;
  logic [BUS-1:0]  y_q, y_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  op_e             op_in;
  logic            b_ge_bus;
  logic [CntW-1:0] load_cnt;
  logic [BUS-1:0]  step_nxt;
  logic            step_msb_changed;

  assign op_in    = op_e'(op);
  assign b_ge_bus = (b >= BUS'(BUS));

  // Shifts saturate at BUS steps; rotates wrap; anything unsupported completes immediately.
  always_comb begin
    load_cnt = '0;
    case (op_in)
      OpSll, OpSrl, OpSla, OpSra: load_cnt = b_ge_bus ? CntW'(BUS) : b[CntW-1:0];
`ifdef SHIFT_ROTATE_EN
      OpRol, OpRor:               load_cnt = {1'b0, b[LogBus-1:0]};
`endif
      default:                    load_cnt = '0;
    endcase
  end

  shift_step #(
    .BUS(BUS)
  ) u_step (
    .op_i         (op_q),
    .val_i        (work_q),
    .nxt_o        (step_nxt),
    .msb_changed_o(step_msb_changed)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          work_d   = a;
          op_d     = op_in;
          cnt_d    = load_cnt;
          sticky_d = 1'b0;
          state_d  = StShift;
          busy_d   = 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          y_d     = work_q;
          ovf_d   = (op_q == OpSla) && sticky_q;
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          work_d = step_nxt;
          cnt_d  = cnt_q - CntW'(1);
          if ((op_q == OpSla) && step_msb_changed) begin
            sticky_d = 1'b1;
          end
          busy_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpSll;
      cnt_q    <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      sticky_q <= sticky_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit against an arithmetic reference model.
module tb_shift_seq_unit;

  localparam int unsigned BUS = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2:0]     op = 3'd0;
  logic [BUS-1:0] a = '0;
  logic [BUS-1:0] b = '0;
  logic           busy;
  logic           done;
  logic [BUS-1:0] y;
  logic           ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_seq_unit #(
    .BUS(BUS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .y    (y),
    .ovf  (ovf)
  );

  // Reference: result as a whole-value arithmetic operation, SLA overflow as signed overflow of a*2^k.
  function automatic void model(input logic [2:0] mop, input logic [BUS-1:0] ma,
                                input logic [BUS-1:0] mb, output logic [BUS-1:0] ey,
                                output logic eovf, output int ecnt);
    int unsigned ua;
    longint      sa, prod, hi, lo;
    int          k, r;
    bit          rot_en;
`ifdef SHIFT_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    ua   = ma;
    sa   = longint'($signed(ma));
    k    = (int'(mb) >= BUS) ? BUS : int'(mb);
    r    = int'(mb) % BUS;
    ey   = ma;
    eovf = 1'b0;
    ecnt = 0;
    case (mop)
      3'd0: begin ey = BUS'(ua << k); ecnt = k; end
      3'd1: begin ey = BUS'(ua >> k); ecnt = k; end
      3'd2: begin
        ey   = BUS'(ua << k);
        ecnt = k;
        prod = sa * (longint'(1) << k);
        hi   = (longint'(1) << (BUS - 1)) - 1;
        lo   = -(longint'(1) << (BUS - 1));
        eovf = (prod > hi) || (prod < lo);
      end
      3'd3: begin ey = BUS'(sa >>> k); ecnt = k; end
      3'd4: if (rot_en) begin ey = BUS'((ua << r) | (ua >> (BUS - r))); ecnt = r; end
      3'd5: if (rot_en) begin ey = BUS'((ua >> r) | (ua << (BUS - r))); ecnt = r; end
      default: ;
    endcase
  endfunction

  // Issue one operation in the next cycle and observe it until done (bounded).
  task automatic do_op(input logic [2:0] top, input logic [BUS-1:0] ta, input logic [BUS-1:0] tb,
                       output int lat, output int bcnt, output logic [BUS-1:0] oy,
                       output logic oovf, output logic obusy, output logic timeout);
    @(posedge clk); #1;
    op = top; a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after acceptance; the unit must have latched them.
    a = BUS'($urandom); b = BUS'($urandom); op = 3'($urandom);
    lat = 1; bcnt = 0; timeout = 1'b1; oy = 'x; oovf = 1'bx; obusy = 1'bx;
    for (int i = 0; i < 4 * BUS + 8; i++) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        timeout = 1'b0; oy = y; oovf = ovf; obusy = busy;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (y !== '0) begin n_fail++; $display("FAIL reset_y: got %h expected 0", y); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]     v_op [11] = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 3'd5, 3'd4, 3'd6, 3'd2};
    logic [BUS-1:0] v_a  [11] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h1, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h8};
    logic [BUS-1:0] v_b  [11] = '{4'h2, 4'h1, 4'h3, 4'h1, 4'h1, 4'h5, 4'h0, 4'h1, 4'h5, 4'h2, 4'hf};
    int lat, bcnt, ecnt;
    logic [BUS-1:0] oy, ey;
    logic oovf, eovf, obusy, tmo;
    for (int i = 0; i < 11; i++) begin
      model(v_op[i], v_a[i], v_b[i], ey, eovf, ecnt);
      do_op(v_op[i], v_a[i], v_b[i], lat, bcnt, oy, oovf, obusy, tmo);
      n_checks++;
      if (tmo) begin
        n_fail++; $display("FAIL dir%0d_timeout: got no done expected done", i);
        continue;
      end
      n_checks++; if (oy !== ey) begin n_fail++; $display("FAIL dir%0d_y: got %h expected %h", i, oy, ey); end
      n_checks++; if (oovf !== eovf) begin n_fail++; $display("FAIL dir%0d_ovf: got %b expected %b", i, oovf, eovf); end
      n_checks++; if (lat != ecnt + 2) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, ecnt + 2); end
      n_checks++; if (bcnt != ecnt + 1) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bcnt, ecnt + 1); end
      n_checks++; if (obusy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, obusy); end
    end
  endtask

  task automatic test_random();
    int lat, bcnt, ecnt;
    logic [2:0] rop;
    logic [BUS-1:0] ra, rb, oy, ey;
    logic oovf, eovf, obusy, tmo;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = BUS'($urandom);
      rb  = BUS'($urandom);
      model(rop, ra, rb, ey, eovf, ecnt);
      do_op(rop, ra, rb, lat, bcnt, oy, oovf, obusy, tmo);
      n_checks++;
      if (tmo || oy !== ey || oovf !== eovf || lat != ecnt + 2 || bcnt != ecnt + 1) begin
        n_fail++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h: got y=%h ovf=%b lat=%0d busy=%0d expected y=%h ovf=%b lat=%0d busy=%0d",
                 i, rop, ra, rb, oy, oovf, lat, bcnt, ey, eovf, ecnt + 2, ecnt + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, ecnt, c1, c2;
    logic [BUS-1:0] oy, ey;
    logic oovf, eovf, obusy, tmo;
    do_op(3'd1, 4'hc, 4'h1, lat, bcnt, oy, oovf, obusy, tmo);
    c1 = cyc;
    model(3'd3, 4'ha, 4'h3, ey, eovf, ecnt);
    do_op(3'd3, 4'ha, 4'h3, lat, bcnt, oy, oovf, obusy, tmo);
    c2 = cyc;
    n_checks++; if (tmo || oy !== ey) begin n_fail++; $display("FAIL b2b_y: got %h expected %h", oy, ey); end
    n_checks++; if (c2 - c1 != ecnt + 3) begin n_fail++; $display("FAIL b2b_period: got %0d expected %0d", c2 - c1, ecnt + 3); end
  endtask

  task automatic test_hold();
    int lat, bcnt, ecnt, bad;
    logic [BUS-1:0] oy, ey;
    logic oovf, eovf, obusy, tmo;
    model(3'd2, 4'h5, 4'h1, ey, eovf, ecnt);
    do_op(3'd2, 4'h5, 4'h1, lat, bcnt, oy, oovf, obusy, tmo);
    bad = 0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = BUS'($urandom); b = BUS'($urandom);
      if (y !== ey || ovf !== eovf || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (tmo || bad != 0) begin n_fail++; $display("FAIL hold_result: got %0d bad idle cycles expected 0", bad); end
  endtask

  task automatic test_start_while_busy();
    int lat, dones;
    logic [BUS-1:0] oy;
    @(posedge clk); #1;
    op = 3'd3; a = 4'h9; b = 4'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 3'd0; a = 4'h6; b = 4'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3; oy = 'x; dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin oy = y; break; end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (oy !== 4'hf) begin n_fail++; $display("FAIL busy_start_y: got %h expected f", oy); end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 6", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL busy_start_queued: got %0d activity cycles expected 0", dones); end
  endtask

  task automatic test_rst_mid();
    int act;
    @(posedge clk); #1;
    op = 3'd0; a = 4'h7; b = 4'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (y !== '0) begin n_fail++; $display("FAIL rst_mid_y: got %h expected 0", y); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf: got %b expected 0", ovf); end
    act = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) act++;
      @(posedge clk); #1;
    end
    n_checks++; if (act != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d activity cycles expected 0", act); end
  endtask

  task automatic test_rst_with_start();
    int lat, bcnt, act;
    logic [BUS-1:0] oy;
    logic oovf, obusy, tmo;
    do_op(3'd3, 4'h9, 4'h5, lat, bcnt, oy, oovf, obusy, tmo);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; op = 3'd1; a = 4'hf; b = 4'h1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_checks++; if (y !== '0) begin n_fail++; $display("FAIL rst_start_y: got %h expected 0", y); end
    act = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) act++;
      @(posedge clk); #1;
    end
    n_checks++; if (act != 0) begin n_fail++; $display("FAIL rst_start_dropped: got %0d activity cycles expected 0", act); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_start_while_busy();
    test_rst_mid();
    test_rst_with_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Multi-cycle iterative shifter for the Lab3 ALU datapath: accepts an operand, a shift amount and an operation on a start pulse, shifts one bit position per clock, and reports the result with a one-cycle done pulse. It is the sequential counterpart of the single-cycle combinational shift units. It sits behind the ALU operation decoder, which initiates transfers; this block is the responder.

## Interface
- BUS, default 4: operand/result width in bits; must be a power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  3  operation: 000 SLL, 001 SRL, 010 SLA, 011 SRA, 100 ROL, 101 ROR, 11x reserved.
- a  in  BUS  operand, signed for SRA/SLA.
- b  in  BUS  shift amount, unsigned.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; y/ovf valid from this cycle on.
- y  out  BUS  result; holds until the next accepted start.
- ovf  out  1  SLA only: sign bit changed during the shift; 0 for other ops.

## Operation
- States: IDLE, SHIFT, DONE (enum in package).
- IDLE: on start=1, latch a into working register, latch op, load counter, clear ovf, go to SHIFT. Otherwise stay.
- Counter load: shifts (SLL/SRL/SLA/SRA) use cnt = min(b, BUS); rotates use cnt = b mod BUS.
- SHIFT: if cnt=0, go to DONE; else apply one single-bit step, decrement cnt, stay.
- Single-bit step: SLL/SLA shift left with zero fill; SRL shift right with zero fill; SRA shift right replicating MSB; ROL/ROR rotate by one.
- SLA: ovf latches 1 (sticky) if any step changes the MSB.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Reserved op (11x): complete with y=a, ovf=0, cnt forced to 0.
- start while busy or in DONE: ignored, no queuing.
- b >= BUS: logical shifts give 0; SRA gives all MSB; SLA gives 0 with ovf=1 when a != 0 and a's MSB or any lower bit eventually toggles the sign.

## Timing
- Reset values: busy=0, done=0, y=0, ovf=0, state IDLE, cnt=0.
- Latency: accepted start at cycle N gives done at cycle N+cnt+2, where cnt is the loaded count. For b=0 or a reserved op, done comes at N+2.
- busy is high on cycles N+1 through N+cnt+1, and low in DONE.
- y and ovf are registered and update only in SHIFT/DONE. They are stable from done until the next accepted start.
- Next start is accepted in the cycle after done, so back-to-back throughput is one operation per cnt+3 cycles.
- rst mid-operation: next cycle in IDLE with all outputs at reset values. The pending result is discarded and no done is produced.
- rst and start in the same cycle: rst wins and start is dropped.

## Configuration
- SHIFT_ROTATE_EN defined: ROL/ROR (100/101) operate as specified.
- SHIFT_ROTATE_EN undefined: 100/101 are treated as reserved (y=a, done at N+2), and the rotate step logic is not compiled.
- op port width is 3 in both builds.

## Structure
- shift_pkg: op encoding enum (SLL, SRL, SLA, SRA, ROL, ROR), state enum (IDLE, SHIFT, DONE), count-width constant $clog2(BUS)+1.
- Sub-module shift_step: combinational single-bit step taking op and the value, producing the next value and an msb_changed flag; instantiated once.
- Top level holds the FSM, counter, working register and ovf flag.

## Test plan
- a=1001, op=SRA, b=0010, start -> done 4 cycles after start; y=1110, ovf=0; busy high for 3 cycles.
- a=1001, op=SRL, b=0001 -> y=0100; a=1001, op=SLL, b=0011 -> y=1000.
- a=1001, op=SLA, b=0001 -> y=0010, ovf=1; a=0001, op=SLA, b=0001 -> y=0010, ovf=0.
- a=1001, op=SRA, b=0101 (>=BUS) -> cnt=4, done 6 cycles after start, y=1111. b=0000 -> y=1001, done 2 cycles after start.
- With SHIFT_ROTATE_EN: a=1001, op=ROR, b=0001 -> y=1100; op=ROL, b=0101 (mod 4 = 1) -> y=0011. Without the macro: op=ROR -> y=1001.
- Assert rst during SHIFT -> no done, y=0, busy=0 next cycle. A start pulsed while busy is ignored, and the first result completes unchanged.
